lmg_ctrl_mm: RTL and testbench
==============================

Name: lmg_ctrl_mm

Overview:
Parametrised Avalon-MM slave that owns the board-state registers, the control and status registers, and the move-result buffer for NUM_ENG parallel legal-move-generator engines. It sits between the HPS/Qsys bus and the engine array. It dispatches a start pulse with a locked board snapshot to every engine, then merges the engines' move streams into one result RAM using round-robin arbitration. Compared with the single-engine control block, it adds multiple channels, byte-enable writes, a W1C status register, abort, overflow detection and an interrupt.

Parameters:
DATA_WIDTH, 32, bus word width; must be 32 (one board row = 8 squares x 4 bits).
ADDR_WIDTH, 15, slave word-address width.
NUM_ENG, 4, engine channel count; allowed values 1, 2, 4, 8.
MOVE_W, 16, move encoding width; must be <= DATA_WIDTH.
MAX_MOVES, 128, result RAM depth; power of 2, <= 256.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
slave_address  in  ADDR_WIDTH  word address
slave_read  in  1  read strobe
slave_write  in  1  write strobe
slave_writedata  in  DATA_WIDTH  write data
slave_byteenable  in  DATA_WIDTH/8  byte lanes for writes
slave_readdata  out  DATA_WIDTH  read data; fixed read latency 1
irq  out  1  done interrupt, level
board_flat  out  8*DATA_WIDTH  locked board; row r occupies bits [32r+31:32r]
eng_start  out  NUM_ENG  1-cycle start pulse per engine
eng_abort  out  NUM_ENG  1-cycle abort pulse per engine
eng_move  in  NUM_ENG*MOVE_W  per-engine move data
eng_valid  in  NUM_ENG  move valid
eng_ready  out  NUM_ENG  move accepted when valid&ready
eng_done  in  NUM_ENG  level; engine has finished (held until next start)

Behaviour:
Register map (word addresses):
- 0x0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 ABORT (write-1 pulse, reads 0), bit2 IRQ_EN (read/write).
- 0x1 STATUS: bit0 BUSY, bit1 DONE (W1C), bit2 OVF (W1C), bits[15:8] COUNT (read-only).
- 0x2-0x9: board rows 0-7, read/write. Byteenable applies per byte.
- 0x10 to 0x10+MAX_MOVES-1: result RAM, read-only, zero-extended MOVE_W. Reads beyond COUNT return stale contents.
- All other addresses read 0; writes to them are ignored.
Read timing: slave_readdata is registered and valid on the cycle after slave_read is sampled. A read with no write does not change any state.
Reset values: slave_readdata=0, irq=0, eng_start=0, eng_abort=0, eng_ready=0, BUSY=DONE=OVF=0, COUNT=0, IRQ_EN=0, board rows=0. Result RAM is not cleared.
FSM states:
- IDLE: a START write moves to DISPATCH, clears COUNT/DONE/OVF and locks the board.
- DISPATCH (1 cycle): eng_start = all ones; move to COLLECT.
- COLLECT: eng_ready = all ones. The round-robin arbiter grants at most one valid engine per cycle. The granted move is written to RAM[COUNT] and COUNT increments. Ungranted engines see eng_ready=0 that cycle. When all eng_done bits are high and no eng_valid is high, move to DONE.
- DONE (1 cycle): set DONE; move to IDLE.
BUSY = state != IDLE. irq = DONE & IRQ_EN.
Overflow: when COUNT == MAX_MOVES, further moves are still accepted (to drain the engines) but discarded, and OVF is set. COUNT saturates at MAX_MOVES.
Collisions and boundary cases:
- START while BUSY: ignored.
- Board writes while BUSY: ignored (board locked).
- START and ABORT in the same write: ABORT wins.
- ABORT while BUSY: eng_abort = all ones for 1 cycle, state returns to IDLE, DONE stays 0, COUNT is retained.
- ABORT while IDLE: no effect.
- A W1C write to STATUS in the same cycle that DONE is set: the set wins.
Reset asserted mid-operation returns the block to IDLE immediately with all register values as listed above.
Arbiter: the pointer advances to the engine after the granted one. The pointer resets to engine 0.

Decomposition:
Package lmg_ctrl_pkg:
- Register offsets (CTRL, STATUS, BOARD_BASE, RESULT_BASE).
- CTRL/STATUS bit indices.
- FSM state enum {IDLE, DISPATCH, COLLECT, DONE}.
- 4-bit piece codes.
Sub-module rr_arbiter (parametrised N): request vector in, one-hot grant out, pointer updates on grant.

Test Plan:
1. Reset, then read 0x0, 0x1 and 0x2-0x9 -> all read 0; irq=0.
2. Write 0x42365324 to 0x2 with byteenable=4'b0011, then read 0x2 -> 0x00005324.
3. Write the board, write CTRL=0x5, model engines 0-3 each emitting 3 moves (0xE0k0+n) simultaneously, then done -> COUNT=12; RAM holds the moves in round-robin order 0,1,2,3,0,...; DONE=1; irq=1; write STATUS=0x2 -> irq=0.
4. With MAX_MOVES=8, engines emit 10 moves total -> COUNT=8, OVF=1, engines drained, DONE=1.
5. START, then write board row 0x3=0xFFFFFFFF while BUSY, then write CTRL=0x2 -> board row unchanged, eng_abort=4'hF for 1 cycle, BUSY=0, DONE=0.
6. Assert reset during COLLECT with COUNT=5 -> next cycle state IDLE, COUNT=0, eng_ready=0, board rows=0.

Source files
------------

// File: rtl/lmg_ctrl_pkg.sv
// Shared register map, bit positions, FSM states and piece codes for the
// multi-engine legal-move-generator control block.
package lmg_ctrl_pkg;

  localparam int CTRL_ADDR   = 0;
  localparam int STATUS_ADDR = 1;
  localparam int BOARD_BASE  = 2;
  localparam int BOARD_ROWS  = 8;
  localparam int RESULT_BASE = 16;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    COLLECT,
    DONE
  } state_t;

  // Nibble encoding of one board square; row word = 8 squares, square 0 in bits [3:0].
  typedef enum logic [3:0] {
    PC_EMPTY   = 4'h0,
    PC_WPAWN   = 4'h1,
    PC_WKNIGHT = 4'h2,
    PC_WBISHOP = 4'h3,
    PC_WROOK   = 4'h4,
    PC_WQUEEN  = 4'h5,
    PC_WKING   = 4'h6,
    PC_BPAWN   = 4'h9,
    PC_BKNIGHT = 4'hA,
    PC_BBISHOP = 4'hB,
    PC_BROOK   = 4'hC,
    PC_BQUEEN  = 4'hD,
    PC_BKING   = 4'hE
  } piece_t;

endpackage

// File: rtl/lmg_ctrl_mm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves to the requester after the one granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_gidx;
  logic             w_found;
  int               w_idx;

  always_comb begin
    o_grant = '0;
    w_gidx  = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(r_ptr) + i) % N;
      if (!w_found && i_req[PTR_W'(w_idx)]) begin
        o_grant[PTR_W'(w_idx)] = 1'b1;
        w_gidx  = PTR_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= PTR_W'((int'(w_gidx) + 1) % N);
    end
  end

endmodule

// File: rtl/lmg_ctrl_mm.sv
// Avalon-MM control slave for NUM_ENG move-generator engines: board registers,
// CTRL/STATUS, start/abort dispatch and a round-robin merged result RAM.
module lmg_ctrl_mm
  import lmg_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_ENG    = 4,
  parameter int MOVE_W     = 16,
  parameter int MAX_MOVES  = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     slave_address,
  input  logic                      slave_read,
  input  logic                      slave_write,
  input  logic [DATA_WIDTH-1:0]     slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]   slave_byteenable,
  output logic [DATA_WIDTH-1:0]     slave_readdata,
  output logic                      irq,
  output logic [8*DATA_WIDTH-1:0]   board_flat,
  output logic [NUM_ENG-1:0]        eng_start,
  output logic [NUM_ENG-1:0]        eng_abort,
  input  logic [NUM_ENG*MOVE_W-1:0] eng_move,
  input  logic [NUM_ENG-1:0]        eng_valid,
  output logic [NUM_ENG-1:0]        eng_ready,
  input  logic [NUM_ENG-1:0]        eng_done
);

  localparam int RAM_AW = $clog2(MAX_MOVES);
  localparam int CNT_W  = RAM_AW + 1;
  localparam int NBYTES = DATA_WIDTH / 8;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_count;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_irq_en;
  logic                  r_abort;
  logic [DATA_WIDTH-1:0] r_board [BOARD_ROWS];
  logic [MOVE_W-1:0]     r_ram [MAX_MOVES];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_hit_ctrl;
  logic                  w_hit_status;
  logic                  w_hit_board;
  logic                  w_hit_result;
  logic [2:0]            w_board_idx;
  logic [RAM_AW-1:0]     w_ram_ridx;
  logic                  w_ctrl_wr;
  logic                  w_st_wr;
  logic                  w_start_req;
  logic                  w_abort_req;
  logic                  w_busy;
  logic                  w_launch;
  logic                  w_kill;
  logic                  w_done_set;
  logic [NUM_ENG-1:0]    w_req;
  logic [NUM_ENG-1:0]    w_grant;
  logic                  w_take;
  logic                  w_full;
  logic [MOVE_W-1:0]     w_move;
  logic [ST_COUNT_W-1:0] w_cnt_field;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_hit_ctrl   = slave_address == ADDR_WIDTH'(CTRL_ADDR);
  assign w_hit_status = slave_address == ADDR_WIDTH'(STATUS_ADDR);
  assign w_hit_board  = (slave_address >= ADDR_WIDTH'(BOARD_BASE)) &&
                        (slave_address <  ADDR_WIDTH'(BOARD_BASE + BOARD_ROWS));
  assign w_hit_result = (slave_address >= ADDR_WIDTH'(RESULT_BASE)) &&
                        (slave_address <  ADDR_WIDTH'(RESULT_BASE + MAX_MOVES));
  assign w_board_idx  = 3'(slave_address[2:0] - 3'(BOARD_BASE));
  assign w_ram_ridx   = RAM_AW'(slave_address[RAM_AW-1:0] - RAM_AW'(RESULT_BASE));

  // ABORT beats START in a single write; either only matters in the right state.
  assign w_ctrl_wr   = slave_write && w_hit_ctrl && slave_byteenable[0];
  assign w_st_wr     = slave_write && w_hit_status && slave_byteenable[0];
  assign w_abort_req = w_ctrl_wr && slave_writedata[CTRL_ABORT];
  assign w_start_req = w_ctrl_wr && slave_writedata[CTRL_START] && !slave_writedata[CTRL_ABORT];
  assign w_busy      = r_state != IDLE;
  assign w_launch    = (r_state == IDLE) && w_start_req;
  assign w_kill      = w_busy && w_abort_req;
  assign w_done_set  = (r_state == DONE) && !w_kill;

  assign w_req  = eng_valid & {NUM_ENG{r_state == COLLECT}};
  assign w_take = |w_grant;
  assign w_full = r_count == CNT_W'(MAX_MOVES);

  rr_arbiter #(
    .N (NUM_ENG)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_move = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (w_grant[i]) begin
        w_move = eng_move[i*MOVE_W +: MOVE_W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start_req) w_next = DISPATCH;
      DISPATCH: w_next = COLLECT;
      COLLECT:  if ((&eng_done) && !(|eng_valid)) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_kill) begin
      w_next = IDLE;
    end
  end

  assign eng_start      = {NUM_ENG{r_state == DISPATCH}};
  assign eng_ready      = w_grant;
  assign eng_abort      = {NUM_ENG{r_abort}};
  assign irq            = r_done & r_irq_en;
  assign slave_readdata = r_rdata;

  // Status flag sets take priority over W1C clears issued in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_abort <= w_kill;
      if (w_ctrl_wr) begin
        r_irq_en <= slave_writedata[CTRL_IRQ_EN];
      end
      if (w_launch) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_take && !w_full) begin
          r_count <= r_count + CNT_W'(1);
        end
        if (w_take && w_full) begin
          r_ovf <= 1'b1;
        end else if (w_st_wr && slave_writedata[ST_OVF]) begin
          r_ovf <= 1'b0;
        end
        if (w_done_set) begin
          r_done <= 1'b1;
        end else if (w_st_wr && slave_writedata[ST_DONE]) begin
          r_done <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < BOARD_ROWS; r++) begin
        r_board[r] <= '0;
      end
    end else if (slave_write && w_hit_board && !w_busy) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (slave_byteenable[b]) begin
          r_board[w_board_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_take && !w_full) begin
      r_ram[r_count[RAM_AW-1:0]] <= w_move;
    end
  end

  always_comb begin
    board_flat = '0;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      board_flat[r*DATA_WIDTH +: DATA_WIDTH] = r_board[r];
    end
  end

  always_comb begin
    w_cnt_field = (int'(r_count) > (1 << ST_COUNT_W) - 1) ? '1 : ST_COUNT_W'(r_count);
    w_rdata     = '0;
    if (w_hit_ctrl) begin
      w_rdata[CTRL_IRQ_EN] = r_irq_en;
    end else if (w_hit_status) begin
      w_rdata[ST_BUSY] = w_busy;
      w_rdata[ST_DONE] = r_done;
      w_rdata[ST_OVF]  = r_ovf;
      w_rdata[ST_COUNT_LSB +: ST_COUNT_W] = w_cnt_field;
    end else if (w_hit_board) begin
      w_rdata = r_board[w_board_idx];
    end else if (w_hit_result) begin
      w_rdata = DATA_WIDTH'(r_ram[w_ram_ridx]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (slave_read) begin
      r_rdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_lmg_ctrl_mm.sv
// Directed self-checking bench for lmg_ctrl_mm with four modelled engines
// and a 16-entry result RAM.
module tb_lmg_ctrl_mm;

  localparam int NENG  = 4;
  localparam int MW    = 16;
  localparam int MAXMV = 16;

  logic                 clk;
  logic                 reset;
  logic [14:0]          slaveAddress;
  logic                 slaveRead;
  logic                 slaveWrite;
  logic [31:0]          slaveWritedata;
  logic [3:0]           slaveByteenable;
  logic [31:0]          slaveReaddata;
  logic                 irq;
  logic [255:0]         boardFlat;
  logic [NENG-1:0]      engStart;
  logic [NENG-1:0]      engAbort;
  logic [NENG*MW-1:0]   engMove;
  logic [NENG-1:0]      engValid;
  logic [NENG-1:0]      engReady;
  logic [NENG-1:0]      engDone;

  int checks   = 0;
  int failures = 0;

  int          cfgMoves [NENG];
  logic        doneEn;
  int          remMoves [NENG];
  int          sentMoves [NENG];
  logic [NENG-1:0] armed;

  lmg_ctrl_mm #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (15),
    .NUM_ENG    (NENG),
    .MOVE_W     (MW),
    .MAX_MOVES  (MAXMV)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slaveAddress),
    .slave_read       (slaveRead),
    .slave_write      (slaveWrite),
    .slave_writedata  (slaveWritedata),
    .slave_byteenable (slaveByteenable),
    .slave_readdata   (slaveReaddata),
    .irq              (irq),
    .board_flat       (boardFlat),
    .eng_start        (engStart),
    .eng_abort        (engAbort),
    .eng_move         (engMove),
    .eng_valid        (engValid),
    .eng_ready        (engReady),
    .eng_done         (engDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine k emits moves 0xE000 + 16*k + n, loading its move budget on eng_start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= '0;
      for (int i = 0; i < NENG; i++) begin
        remMoves[i]  <= 0;
        sentMoves[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NENG; i++) begin
        if (engStart[i]) begin
          remMoves[i]  <= cfgMoves[i];
          sentMoves[i] <= 0;
          armed[i]     <= 1'b1;
        end else if (engAbort[i]) begin
          remMoves[i] <= 0;
          armed[i]    <= 1'b0;
        end else if (engValid[i] && engReady[i]) begin
          remMoves[i]  <= remMoves[i] - 1;
          sentMoves[i] <= sentMoves[i] + 1;
        end
      end
    end
  end

  always_comb begin
    engValid = '0;
    engDone  = '0;
    engMove  = '0;
    for (int i = 0; i < NENG; i++) begin
      engValid[i] = remMoves[i] > 0;
      engDone[i]  = armed[i] && (remMoves[i] == 0) && doneEn;
      engMove[i*MW +: MW] = 16'(32'hE000 + i*16 + sentMoves[i]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input int addr, input logic [31:0] data, input logic [3:0] be);
    @(posedge clk);
    #1;
    slaveAddress    = 15'(addr);
    slaveWritedata  = data;
    slaveByteenable = be;
    slaveWrite      = 1'b1;
    @(posedge clk);
    #1;
    slaveWrite      = 1'b0;
    slaveByteenable = 4'h0;
  endtask

  task automatic busRead(input int addr, output logic [31:0] data);
    @(posedge clk);
    #1;
    slaveAddress = 15'(addr);
    slaveRead    = 1'b1;
    @(posedge clk);
    #1;
    slaveRead = 1'b0;
    data      = slaveReaddata;
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int k = 0; k < 200; k++) begin
      busRead(1, st);
      if (!st[0]) break;
    end
    checkOutput(tag, {31'b0, st[0]}, 32'h0);
  endtask

  task automatic applyStimulus();
    logic [31:0] rd;

    // Reset state
    reset = 1'b0;
    slaveAddress = '0; slaveRead = 1'b0; slaveWrite = 1'b0;
    slaveWritedata = '0; slaveByteenable = '0;
    doneEn = 1'b0;
    for (int i = 0; i < NENG; i++) cfgMoves[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int a = 0; a < 10; a++) begin
      busRead(a, rd);
      checkOutput($sformatf("reset_read_%0d", a), rd, 32'h0);
    end
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);

    // Unmapped address ignores writes
    busWrite(32'hA, 32'hFFFFFFFF, 4'hF);
    busRead(32'hA, rd);
    checkOutput("unmapped_read", rd, 32'h0);

    // Byte-enable board write
    busWrite(2, 32'h42365324, 4'b0011);
    busRead(2, rd);
    checkOutput("row0_byteen", rd, 32'h00005324);

    // Normal run, 4 engines x 3 moves
    busWrite(3, 32'h87654321, 4'hF);
    checkOutput("board_flat_row1", boardFlat[63:32], 32'h87654321);
    for (int i = 0; i < NENG; i++) cfgMoves[i] = 3;
    doneEn = 1'b1;
    busWrite(0, 32'h5, 4'hF);
    waitIdle("run3_timeout");
    busRead(1, rd);
    checkOutput("run3_status", rd, 32'h00000C02);
    checkOutput("run3_irq", {31'b0, irq}, 32'h1);
    busRead(0, rd);
    checkOutput("ctrl_readback", rd, 32'h4);
    for (int j = 0; j < 12; j++) begin
      busRead(16 + j, rd);
      checkOutput($sformatf("run3_ram_%0d", j), rd, 32'hE000 + (j % 4) * 16 + (j / 4));
    end
    busWrite(1, 32'h2, 4'hF);
    checkOutput("run3_irq_clear", {31'b0, irq}, 32'h0);
    busRead(1, rd);
    checkOutput("run3_status_w1c", rd, 32'h00000C00);

    // Overflow: 20 moves into a 16-entry buffer
    for (int i = 0; i < NENG; i++) cfgMoves[i] = 5;
    busWrite(0, 32'h5, 4'hF);
    waitIdle("ovf_timeout");
    busRead(1, rd);
    checkOutput("ovf_status", rd, 32'h00001006);
    checkOutput("ovf_drained", {28'b0, engValid}, 32'h0);
    busRead(16, rd);
    checkOutput("ovf_ram_0", rd, 32'hE000);
    busRead(31, rd);
    checkOutput("ovf_ram_15", rd, 32'hE033);
    busWrite(1, 32'h4, 4'hF);
    busRead(1, rd);
    checkOutput("ovf_w1c_ovf_only", rd, 32'h00001002);
    busWrite(1, 32'h2, 4'hF);
    busRead(1, rd);
    checkOutput("ovf_w1c_done", rd, 32'h00001000);

    // Start, locked board, abort
    for (int i = 0; i < NENG; i++) cfgMoves[i] = 0;
    doneEn = 1'b0;
    busWrite(0, 32'h1, 4'hF);
    checkOutput("start_pulse", {28'b0, engStart}, 32'hF);
    @(posedge clk);
    #1;
    checkOutput("start_pulse_end", {28'b0, engStart}, 32'h0);
    busRead(1, rd);
    checkOutput("busy_status", rd, 32'h00000001);
    busWrite(3, 32'hFFFFFFFF, 4'hF);
    busRead(3, rd);
    checkOutput("locked_row1", rd, 32'h87654321);
    busWrite(0, 32'h1, 4'hF);
    checkOutput("start_while_busy", {28'b0, engStart}, 32'h0);
    busWrite(0, 32'h2, 4'hF);
    checkOutput("abort_pulse", {28'b0, engAbort}, 32'hF);
    @(posedge clk);
    #1;
    checkOutput("abort_pulse_end", {28'b0, engAbort}, 32'h0);
    busRead(1, rd);
    checkOutput("abort_status", rd, 32'h0);

    // START+ABORT together while idle does nothing
    busWrite(0, 32'h3, 4'hF);
    checkOutput("start_abort_nostart", {28'b0, engStart}, 32'h0);
    checkOutput("start_abort_noabort", {28'b0, engAbort}, 32'h0);
    busRead(1, rd);
    checkOutput("start_abort_status", rd, 32'h0);

    // Reset in the middle of COLLECT
    busWrite(2, 32'hCAFEF00D, 4'hF);
    cfgMoves[0] = 5;
    busWrite(0, 32'h1, 4'hF);
    repeat (10) @(posedge clk);
    busRead(1, rd);
    checkOutput("collect5_status", rd, 32'h00000501);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_eng_ready", {28'b0, engReady}, 32'h0);
    checkOutput("rst_board_lo", boardFlat[31:0], 32'h0);
    checkOutput("rst_board_hi", boardFlat[63:32], 32'h0);
    checkOutput("rst_readdata", slaveReaddata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    busRead(1, rd);
    checkOutput("rst_status", rd, 32'h0);
    busRead(2, rd);
    checkOutput("rst_row0", rd, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
